spi_master_gen: RTL

Parametrised APB-programmable SPI master, the next generation of the team's single-mode SPI master. It adds all four CPOL/CPHA modes, a programmable SCLK divider, multiple chip selects, a full-duplex TX/RX byte buffer of configurable depth, and a completion interrupt. It sits on the peripheral APB bus as a slave and drives one external SPI bus.

---
 rtl/spi_master_gen.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/spi_master_gen.sv
`timescale 1ns/1ps
// spi_master_gen: APB-programmable SPI master with all four CPOL/CPHA modes,
// programmable SCLK divider, NUM_CS chip selects and a DEPTH-byte TX/RX buffer.
//
// Ports:
//   pclk_i, preset_i                 clock, asynchronous active-high reset
//   paddr_i/psel_i/penable_i/
//   pwrite_i/pwdata_i                APB slave request
//   pready_o/prdata_o/pslverr_o      APB slave response (zero wait state)
//   irq_o                            completion interrupt (STATUS.done)
//   miso_i, sclk_o, mosi_o, cs_n_o   SPI bus
//
// Optional feature: define SPI_LSB_FIRST_EN to implement CTRL[3] (LSB-first).
module spi_master_gen #(
   parameter int unsigned DEPTH  = 8,
   parameter int unsigned NUM_CS = 2,
   parameter int unsigned DIV_W  = 8
) (
   input  logic              pclk_i,
   input  logic              preset_i,
   input  logic [7:0]        paddr_i,
   input  logic              psel_i,
   input  logic              penable_i,
   input  logic              pwrite_i,
   input  logic [7:0]        pwdata_i,
   output logic              pready_o,
   output logic [7:0]        prdata_o,
   output logic              pslverr_o,
   output logic              irq_o,
   input  logic              miso_i,
   output logic              sclk_o,
   output logic              mosi_o,
   output logic [NUM_CS-1:0] cs_n_o
);
   localparam int unsigned BW       = (DEPTH  > 1) ? $clog2(DEPTH)  : 1;
   localparam int unsigned CSW      = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
   localparam logic [7:0]  DEPTH_B  = 8'(DEPTH);
   localparam logic [7:0]  NUM_CS_B = 8'(NUM_CS);

   typedef enum logic [1:0] {S_IDLE, S_LEAD, S_XFER, S_TRAIL} state_t;
   state_t state_q, state_d;

   logic             cpol_q, cpha_q, lsb_q, done_q;
   logic [DIV_W-1:0] div_q, cnt_q;
   logic [7:0]       len_q, len_eff;
   logic [CSW-1:0]   cssel_q;
   logic [7:0]       tx_mem [DEPTH];
   logic [7:0]       rx_mem [DEPTH];
   logic [7:0]       tx_sh, rx_sh, rx_bits;
   logic [3:0]       h_q, h_d;          // half-period index inside the current byte
   logic [BW-1:0]    byte_q, byte_d, addr_idx;
   logic             busy, wr_en, reject, wr_ok, ctrl_wr, start_ok, last_byte, tick;
   logic             tx_hit, rx_hit, lead_edge, trail_edge, set_done, shift_ev, samp_ev;

   assign busy      = (state_q != S_IDLE);
   assign wr_en     = psel_i & penable_i & pwrite_i;
   assign reject    = wr_en && ((busy && (paddr_i != 8'h01)) ||
                                ((paddr_i == 8'h04) && (pwdata_i >= NUM_CS_B)));
   assign wr_ok     = wr_en && !reject;
   assign ctrl_wr   = wr_ok && (paddr_i == 8'h00);
   assign len_eff   = (len_q > DEPTH_B) ? DEPTH_B : len_q;
   assign start_ok  = ctrl_wr && pwdata_i[0] && (len_eff != 8'd0);
   assign last_byte = (8'(byte_q) == (len_eff - 8'd1));
   assign tick      = busy && (cnt_q == div_q);
   assign addr_idx  = paddr_i[BW-1:0];
   assign tx_hit    = (paddr_i[7:4] == 4'h1) && ({4'h0, paddr_i[3:0]} < DEPTH_B);
   assign rx_hit    = (paddr_i[7:4] == 4'h2) && ({4'h0, paddr_i[3:0]} < DEPTH_B);

   // Entering an even half period is a leading SCLK edge, odd is trailing.
   always_comb begin
      state_d    = state_q;
      h_d        = h_q;
      byte_d     = byte_q;
      lead_edge  = 1'b0;
      trail_edge = 1'b0;
      set_done   = 1'b0;
      case (state_q)
         S_IDLE: begin
            h_d    = '0;
            byte_d = '0;
            if (start_ok) state_d = S_LEAD;
         end
         S_LEAD: if (tick) begin
            state_d   = S_XFER;
            h_d       = '0;
            lead_edge = 1'b1;
         end
         S_XFER: if (tick) begin
            if (h_q == 4'd15) begin
               if (last_byte) state_d = S_TRAIL;
               else begin
                  byte_d    = byte_q + 1'b1;
                  h_d       = '0;
                  lead_edge = 1'b1;
               end
            end else begin
               h_d = h_q + 4'd1;
               if (h_q[0]) lead_edge  = 1'b1;
               else        trail_edge = 1'b1;
            end
         end
         S_TRAIL: if (tick) begin
            state_d  = S_IDLE;
            set_done = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge pclk_i or posedge preset_i) begin
      if (preset_i) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   assign shift_ev = cpha_q ? lead_edge  : trail_edge;
   assign samp_ev  = cpha_q ? trail_edge : lead_edge;
   assign rx_bits  = lsb_q ? {miso_i, rx_sh[7:1]} : {rx_sh[6:0], miso_i};

   always_ff @(posedge pclk_i or posedge preset_i) begin
      if (preset_i) begin
         h_q     <= '0;
         byte_q  <= '0;
         cnt_q   <= '0;
         cpol_q  <= 1'b0;
         cpha_q  <= 1'b0;
         done_q  <= 1'b0;
         div_q   <= '0;
         len_q   <= '0;
         cssel_q <= '0;
         tx_sh   <= '0;
         rx_sh   <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            tx_mem[i] <= '0;
            rx_mem[i] <= '0;
         end
      end else begin
         h_q    <= h_d;
         byte_q <= byte_d;
         if (!busy || tick) cnt_q <= '0;
         else               cnt_q <= cnt_q + 1'b1;

         if (ctrl_wr) begin
            cpol_q <= pwdata_i[1];
            cpha_q <= pwdata_i[2];
         end
         if (wr_ok && (paddr_i == 8'h02)) div_q   <= DIV_W'(pwdata_i);
         if (wr_ok && (paddr_i == 8'h03)) len_q   <= pwdata_i;
         if (wr_ok && (paddr_i == 8'h04)) cssel_q <= CSW'(pwdata_i);
         if (wr_ok && tx_hit)             tx_mem[addr_idx] <= pwdata_i;

         // Completion wins over a same-cycle write-1-to-clear.
         if (set_done)                                          done_q <= 1'b1;
         else if (start_ok)                                     done_q <= 1'b0;
         else if (wr_ok && (paddr_i == 8'h01) && pwdata_i[1])   done_q <= 1'b0;

         // The next byte is loaded on the shift edge that would present its first bit.
         if (start_ok) tx_sh <= tx_mem[0];
         else if (shift_ev) begin
            if (cpha_q && (h_d == 4'd0))
               tx_sh <= tx_mem[byte_d];
            else if (!cpha_q && (h_d == 4'd15) && !last_byte)
               tx_sh <= tx_mem[byte_q + 1'b1];
            else
               tx_sh <= lsb_q ? {1'b0, tx_sh[7:1]} : {tx_sh[6:0], 1'b0};
         end

         if (samp_ev) begin
            rx_sh <= rx_bits;
            if (h_d == (cpha_q ? 4'd15 : 4'd14)) rx_mem[byte_q] <= rx_bits;
         end
      end
   end

`ifdef SPI_LSB_FIRST_EN
   always_ff @(posedge pclk_i or posedge preset_i) begin
      if (preset_i)     lsb_q <= 1'b0;
      else if (ctrl_wr) lsb_q <= pwdata_i[3];
   end
`else
   assign lsb_q = 1'b0;
`endif

   always_comb begin
      cs_n_o = '1;
      for (int unsigned i = 0; i < NUM_CS; i++)
         cs_n_o[i] = ~(busy && (cssel_q == CSW'(i)));
   end

   always_comb begin
      prdata_o = '0;
      case (paddr_i)
         8'h00:   prdata_o = {4'h0, lsb_q, cpha_q, cpol_q, 1'b0};
         8'h01:   prdata_o = {6'h0, done_q, busy};
         8'h02:   prdata_o = 8'(div_q);
         8'h03:   prdata_o = len_q;
         8'h04:   prdata_o = 8'(cssel_q);
         default: begin
            if (tx_hit)      prdata_o = tx_mem[addr_idx];
            else if (rx_hit) prdata_o = rx_mem[addr_idx];
         end
      endcase
   end

   assign sclk_o    = cpol_q ^ ((state_q == S_XFER) && !h_q[0]);
   assign mosi_o    = ((state_q == S_LEAD) || (state_q == S_XFER)) ?
                      (lsb_q ? tx_sh[0] : tx_sh[7]) : 1'b0;
   assign pready_o  = 1'b1;
   assign pslverr_o = reject;
   assign irq_o     = done_q;

endmodule
